// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources, one byte per grant.
// Latency: req sampled in IDLE -> gnt/tx_din next cycle, tx_start the cycle after; 3 cycles overhead per byte.
// Backpressure: requesters hold req and data until gnt; the next grant waits for tx_done_tick or the watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 100000,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               tx_start,
    output logic [7:0]         tx_din,
    input  logic               tx_done_tick,
    output logic               busy,
    output logic               timeout_err
);

    localparam int              IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [IW-1:0]     win, win_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic              tx_start_nxt;
    logic [7:0]        tx_din_nxt;
    logic              busy_nxt;
    logic              timeout_err_nxt;

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic [7:0]        pick_byte;
    logic [IW-1:0]     ptr_adv;

    // Winner is the requester with the smallest rotational distance from ptr.
    always_comb begin
        int best_d;
        int d;
        best_d   = N_REQ;
        d        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + N_REQ;
            end
            if (req[i] && (d < best_d)) begin
                best_d   = d;
                pick_vld = 1'b1;
                pick_idx = IW'(i);
            end
        end
    end

    always_comb begin
        pick_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    assign ptr_adv = (win == IDX_LAST) ? '0 : win + IW'(1);

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        win_nxt         = win;
        cnt_nxt         = cnt;
        gnt_nxt         = '0;
        tx_start_nxt    = 1'b0;
        tx_din_nxt      = tx_din;
        timeout_err_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    tx_din_nxt = pick_byte;
                    gnt_nxt    = N_REQ'(1) << pick_idx;
                    win_nxt    = pick_idx;
                    state_nxt  = S_START;
                end
            end
            S_START: begin
                tx_start_nxt = 1'b1;
                cnt_nxt      = '0;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final count takes priority over the watchdog.
                if (tx_done_tick) begin
                    ptr_nxt   = ptr_adv;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_err_nxt = 1'b1;
                    ptr_nxt         = ptr_adv;
                    state_nxt       = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            tx_start    <= 1'b0;
            tx_din      <= 8'h00;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ptr         <= ptr_nxt;
            win         <= win_nxt;
            cnt         <= cnt_nxt;
            gnt         <= gnt_nxt;
            tx_start    <= tx_start_nxt;
            tx_din      <= tx_din_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_arbiter: transfer table plus stray-done, reset and watchdog sequences.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic        done;
    logic [1:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        busy;
    logic        terr;

    logic [1:0]  w_req;
    logic [15:0] w_data;
    logic        w_done;
    logic [1:0]  w_gnt;
    logic        w_start;
    logic [7:0]  w_din;
    logic        w_busy;
    logic        w_terr;

    uart_tx_arbiter #(.N_REQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (done),
        .busy         (busy),
        .timeout_err  (terr)
    );

    uart_tx_arbiter #(.N_REQ(2), .TIMEOUT(16)) wd (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (w_req),
        .req_data     (w_data),
        .gnt          (w_gnt),
        .tx_start     (w_start),
        .tx_din       (w_din),
        .tx_done_tick (w_done),
        .busy         (w_busy),
        .timeout_err  (w_terr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] b0;
        logic [7:0] b1;
        int         dly;
        logic [1:0] exp_gnt;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Simultaneous after reset, then the other requester.
        vecs[0] = '{2'b11, 8'h31, 8'h32, 5,  2'b01, 8'h31};
        vecs[1] = '{2'b11, 8'h33, 8'h32, 5,  2'b10, 8'h32};
        // Single request with a 20-cycle frame, then a wrap from ptr=1.
        vecs[2] = '{2'b01, 8'h41, 8'h00, 20, 2'b01, 8'h41};
        vecs[3] = '{2'b01, 8'h55, 8'h00, 3,  2'b01, 8'h55};
        vecs[4] = '{2'b10, 8'h00, 8'h66, 3,  2'b10, 8'h66};
        // Continuous contention: 0,1,0,1,0,1 with fresh data each time.
        for (int k = 0; k < 6; k++) begin
            vecs[5+k] = '{2'b11, 8'hA0 + 8'(k), 8'hB0 + 8'(k), 2,
                          (k % 2 == 0) ? 2'b01 : 2'b10,
                          (k % 2 == 0) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k)};
        end

        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        done     = 1'b0;
        w_req    = '0;
        w_data   = '0;
        w_done   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", terr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req      = vecs[i].req;
            req_data = {vecs[i].b1, vecs[i].b0};
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), gnt, vecs[i].exp_gnt);
            check($sformatf("v%0d_din", i), tx_din, vecs[i].exp_byte);
            check($sformatf("v%0d_busy_up", i), busy, 1);
            @(negedge clk);
            check($sformatf("v%0d_tx_start", i), tx_start, 1);
            check($sformatf("v%0d_gnt_pulse", i), gnt, 0);
            @(negedge clk);
            check($sformatf("v%0d_tx_start_pulse", i), tx_start, 0);
            repeat (vecs[i].dly) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check($sformatf("v%0d_busy_down", i), busy, 0);
            check($sformatf("v%0d_no_terr", i), terr, 0);
            check($sformatf("v%0d_din_hold", i), tx_din, vecs[i].exp_byte);
        end
        req = '0;

        // Stray done in IDLE, then done held across the IDLE and START edges.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("stray_idle_busy", busy, 0);
        check("stray_idle_gnt", gnt, 0);
        req      = 2'b01;
        req_data = 16'h0077;
        done     = 1'b1;
        @(negedge clk);
        check("stray_gnt", gnt, 2'b01);
        check("stray_din", tx_din, 8'h77);
        req = '0;
        @(negedge clk);
        done = 1'b0;
        check("stray_tx_start", tx_start, 1);
        repeat (3) @(negedge clk);
        check("stray_still_waiting", busy, 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("stray_fresh_done", busy, 0);
        check("stray_no_terr", terr, 0);

        // Asynchronous reset while in WAIT with tx_start high.
        req      = 2'b01;
        req_data = 16'h0099;
        @(negedge clk);
        check("rw_gnt", gnt, 2'b01);
        req = '0;
        @(negedge clk);
        check("rw_tx_start", tx_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_tx_start_clr", tx_start, 0);
        check("rw_gnt_clr", gnt, 0);
        check("rw_din_clr", tx_din, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        req      = 2'b10;
        req_data = 16'h5A00;
        @(negedge clk);
        check("rw_after_gnt", gnt, 2'b10);
        check("rw_after_din", tx_din, 8'h5A);
        req = '0;
        @(negedge clk);
        check("rw_after_start", tx_start, 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("rw_after_busy", busy, 0);

        // Watchdog with TIMEOUT=16 and no done; requester 1 stays pending.
        w_req  = 2'b11;
        w_data = 16'hC1C0;
        @(negedge clk);
        check("wd_gnt0", w_gnt, 2'b01);
        check("wd_din0", w_din, 8'hC0);
        w_req = 2'b10;
        @(negedge clk);
        check("wd_tx_start", w_start, 1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("wd_quiet%0d", k), {w_terr, w_busy}, 2'b01);
        end
        @(negedge clk);
        check("wd_fire", w_terr, 1);
        check("wd_idle", w_busy, 0);
        @(negedge clk);
        check("wd_once", w_terr, 0);
        check("wd_next_gnt", w_gnt, 2'b10);
        check("wd_next_din", w_din, 8'hC1);
        w_req = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
